// File: rtl/model_vector_signed_integer_divider.sv
// model_vector_signed_integer_divider: radix-2 restoring vector divider; signed mode compiled in with MODEL_VECTOR_INTEGER_DIVIDER_SIGNED_EN
module model_vector_signed_integer_divider #(
   parameter int DATA_SIZE = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 SIGNED_MODE,
   input  logic                 DATA_A_IN_ENABLE,
   input  logic                 DATA_B_IN_ENABLE,
   output logic                 DATA_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_IN,
   input  logic [DATA_SIZE-1:0] DATA_A_IN,
   input  logic [DATA_SIZE-1:0] DATA_B_IN,
   output logic [DATA_SIZE-1:0] DATA_OUT,
   output logic [DATA_SIZE-1:0] REST_OUT,
   output logic                 DIV_ZERO_OUT
);
   localparam int CW = $clog2(DATA_SIZE);
   typedef enum logic [1:0] {IDLE, INPUT, DIVIDE, OUTPUT} state_t;
   state_t state, state_n;
   logic [DATA_SIZE-1:0] size_r, elem, a_r, b_r, q, r, a_mag, b_mag, r_nx, q_out, r_out;
   logic [DATA_SIZE:0] r_sh, r_diff;
   logic [CW-1:0] cnt;
   logic a_ok, b_ok, pair, last, ge, dz, a_neg, b_neg;
`ifdef MODEL_VECTOR_INTEGER_DIVIDER_SIGNED_EN
   logic sg;
   always_ff @(posedge CLK or posedge RST)
      if (RST) sg <= 1'b0;
      else if (state == IDLE && START) sg <= SIGNED_MODE;
   assign a_neg = sg & a_r[DATA_SIZE-1];
   assign b_neg = sg & b_r[DATA_SIZE-1];
`else
   logic sm_unused;
   assign sm_unused = SIGNED_MODE;
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
`endif
   assign pair   = (a_ok | DATA_A_IN_ENABLE) & (b_ok | DATA_B_IN_ENABLE);
   assign last   = elem == size_r - DATA_SIZE'(1);
   assign a_mag  = a_neg ? -a_r : a_r;
   assign b_mag  = b_neg ? -b_r : b_r;
   assign r_sh   = {r, a_mag[CW'(DATA_SIZE-1) - cnt]};
   assign r_diff = r_sh - {1'b0, b_mag};
   assign ge     = r_sh >= {1'b0, b_mag};
   assign r_nx   = ge ? r_diff[DATA_SIZE-1:0] : r_sh[DATA_SIZE-1:0];
   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = state == IDLE   ? ((START && SIZE_IN != '0) ? INPUT : IDLE) :
                state == INPUT  ? (pair ? DIVIDE : INPUT) :
                state == DIVIDE ? ((cnt == CW'(DATA_SIZE-1)) ? OUTPUT : DIVIDE) :
                (last ? IDLE : INPUT);
   always_comb begin
      dz    = b_r == '0;
      q_out = dz ? '1 : ((a_neg ^ b_neg) ? -q : q);
      r_out = dz ? a_r : (a_neg ? -r : r);
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         size_r          <= '0;
         elem            <= '0;
         a_r             <= '0;
         b_r             <= '0;
         a_ok            <= 1'b0;
         b_ok            <= 1'b0;
         q               <= '0;
         r               <= '0;
         cnt             <= '0;
         READY           <= 1'b0;
         DATA_OUT_ENABLE <= 1'b0;
         DATA_OUT        <= '0;
         REST_OUT        <= '0;
         DIV_ZERO_OUT    <= 1'b0;
      end else begin
         READY           <= 1'b0;
         DATA_OUT_ENABLE <= 1'b0;
         case (state)
            IDLE: if (START) begin
               size_r <= SIZE_IN;
               elem   <= '0;
               READY  <= SIZE_IN == '0;
            end
            INPUT: begin
               if (DATA_A_IN_ENABLE) begin
                  a_r  <= DATA_A_IN;
                  a_ok <= 1'b1;
               end
               if (DATA_B_IN_ENABLE) begin
                  b_r  <= DATA_B_IN;
                  b_ok <= 1'b1;
               end
               if (pair) begin
                  a_ok <= 1'b0;
                  b_ok <= 1'b0;
                  q    <= '0;
                  r    <= '0;
                  cnt  <= '0;
               end
            end
            DIVIDE: begin
               r   <= r_nx;
               q   <= {q[DATA_SIZE-2:0], ge};
               cnt <= cnt + CW'(1);
            end
            default: begin
               DATA_OUT        <= q_out;
               REST_OUT        <= r_out;
               DIV_ZERO_OUT    <= dz;
               DATA_OUT_ENABLE <= 1'b1;
               READY           <= last;
               elem            <= elem + DATA_SIZE'(1);
            end
         endcase
      end
endmodule

// File: tb/tb_model_vector_signed_integer_divider.sv
// tb_model_vector_signed_integer_divider: directed vectors with hand-computed quotients and remainders
module tb_model_vector_signed_integer_divider;
   localparam int W = 8;
`ifdef MODEL_VECTOR_INTEGER_DIVIDER_SIGNED_EN
   localparam bit S = 1'b1;
`else
   localparam bit S = 1'b0;
`endif
   logic CLK = 1'b0, RST, START, SIGNED_MODE, A_EN, B_EN;
   logic READY, DOE, DZ;
   logic [W-1:0] SIZE_IN, A, B, DO, RO;
   int n_chk = 0, n_fail = 0;
   int lat, pulses;
   logic rdy;
   always #5 CLK = ~CLK;
   model_vector_signed_integer_divider #(.DATA_SIZE(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIGNED_MODE(SIGNED_MODE),
      .DATA_A_IN_ENABLE(A_EN), .DATA_B_IN_ENABLE(B_EN), .DATA_OUT_ENABLE(DOE),
      .SIZE_IN(SIZE_IN), .DATA_A_IN(A), .DATA_B_IN(B), .DATA_OUT(DO), .REST_OUT(RO),
      .DIV_ZERO_OUT(DZ)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic start_vec(input logic [W-1:0] n, input logic sm);
      @(negedge CLK);
      START = 1'b1;
      SIZE_IN = n;
      SIGNED_MODE = sm;
      @(negedge CLK);
      START = 1'b0;
      SIZE_IN = '0;
      SIGNED_MODE = ~sm;
   endtask
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit bfirst, input bit poke);
      @(negedge CLK);
      if (bfirst) begin
         B = b;
         B_EN = 1'b1;
         @(negedge CLK);
         B_EN = 1'b0;
         B = 8'h55;
         repeat (2) @(negedge CLK);
         A = a;
         A_EN = 1'b1;
      end else begin
         A = a;
         B = b;
         A_EN = 1'b1;
         B_EN = 1'b1;
      end
      @(posedge CLK);
      #1;
      A_EN = 1'b0;
      B_EN = 1'b0;
      A = 8'h33;
      B = 8'h44;
      lat = 0;
      rdy = 1'b0;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         if (poke && i == 3) begin
            START = 1'b1;
            SIZE_IN = 8'd5;
         end
         @(posedge CLK);
         #1;
         START = 1'b0;
         if (DOE) begin
            lat = i;
            rdy = READY;
         end
      end
   endtask
   task automatic elem(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit bfirst,
                       input bit poke, input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input logic erdy);
      send(a, b, bfirst, poke);
      check({tag, ".lat"}, 64'(lat), 64'(W + 1));
      check({tag, ".q"}, 64'(DO), 64'(eq));
      check({tag, ".r"}, 64'(RO), 64'(er));
      check({tag, ".dz"}, 64'(DZ), 64'(edz));
      check({tag, ".ready"}, 64'(rdy), 64'(erdy));
      @(posedge CLK);
      #1;
      check({tag, ".doe_pulse"}, 64'(DOE), 64'(0));
      check({tag, ".hold"}, 64'({DO, RO}), 64'({eq, er}));
   endtask
   initial begin
      RST = 1'b1;
      START = 1'b0;
      SIGNED_MODE = 1'b0;
      A_EN = 1'b0;
      B_EN = 1'b0;
      SIZE_IN = '0;
      A = '0;
      B = '0;
      #1;
      check("rst.outs", 64'({READY, DOE, DZ, DO, RO}), 64'(0));
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      start_vec(8'd1, 1'b0);
      elem("unsigned", 8'd100, 8'd7, 1'b0, 1'b0, 8'd14, 8'd2, 1'b0, 1'b1);
      start_vec(8'd2, 1'b1);
      elem("signed0", 8'hF9, 8'h02, 1'b0, 1'b0, S ? 8'hFD : 8'h7C, S ? 8'hFF : 8'h01, 1'b0, 1'b0);
      elem("signed1", 8'h07, 8'hFE, 1'b0, 1'b0, S ? 8'hFD : 8'h00, S ? 8'h01 : 8'h07, 1'b0, 1'b1);
      start_vec(8'd2, 1'b0);
      elem("dz_u", 8'd5, 8'd0, 1'b0, 1'b0, 8'hFF, 8'd5, 1'b1, 1'b0);
      elem("after_dz_u", 8'd9, 8'd3, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b1);
      start_vec(8'd2, 1'b1);
      elem("dz_s", 8'd5, 8'd0, 1'b0, 1'b0, 8'hFF, 8'd5, 1'b1, 1'b0);
      elem("after_dz_s", 8'd9, 8'd3, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b1);
      start_vec(8'd1, 1'b1);
      elem("overflow", 8'h80, 8'hFF, 1'b0, 1'b0, S ? 8'h80 : 8'h00, S ? 8'h00 : 8'h80, 1'b0, 1'b1);
      start_vec(8'd1, 1'b0);
      elem("b_first", 8'd100, 8'd7, 1'b1, 1'b0, 8'd14, 8'd2, 1'b0, 1'b1);
      start_vec(8'd1, 1'b0);
      elem("start_in_div", 8'd50, 8'd6, 1'b0, 1'b1, 8'd8, 8'd2, 1'b0, 1'b1);
      @(negedge CLK);
      START = 1'b1;
      SIZE_IN = '0;
      @(posedge CLK);
      #1;
      check("size0.ready", 64'(READY), 64'(1));
      check("size0.doe", 64'(DOE), 64'(0));
      START = 1'b0;
      @(posedge CLK);
      #1;
      check("size0.ready_pulse", 64'(READY), 64'(0));
      start_vec(8'd4, 1'b1);
      elem("pre_rst", 8'd100, 8'd7, 1'b0, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
      @(negedge CLK);
      A = 8'd20;
      B = 8'd3;
      A_EN = 1'b1;
      B_EN = 1'b1;
      @(negedge CLK);
      A_EN = 1'b0;
      B_EN = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      check("mid_rst.outs", 64'({READY, DOE, DZ, DO, RO}), 64'(0));
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(posedge CLK);
         #1;
         if (DOE || READY) pulses++;
      end
      check("mid_rst.no_pulse", 64'(pulses), 64'(0));
      start_vec(8'd1, 1'b0);
      elem("post_rst", 8'd9, 8'd3, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
